// File: rtl/jt51_lfo_bank.sv
// jt51_lfo_bank: CH independent LFOs sharing one time-multiplexed
// phase-accumulator core, one channel refreshed per cen tick.
module jt51_lfo_bank #(
   parameter int CH = 4,
   parameter int PW = 20,
   parameter int CW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cen,
   input  logic            cfg_we,
   input  logic [CW-1:0]   cfg_ch,
   input  logic [7:0]      cfg_freq,
   input  logic [1:0]      cfg_w,
   input  logic [6:0]      cfg_amd,
   input  logic [6:0]      cfg_pmd,
   input  logic            cfg_up,
   input  logic [1:0]      test,
   output logic [CH*8-1:0] am,
   output logic [CH*8-1:0] pm,
   output logic            upd,
   output logic [CW-1:0]   upd_ch
);

   localparam logic [14:0] LFSR_INIT = 15'h7fff;
   localparam logic [1:0]  W_SAW = 2'd0;
   localparam logic [1:0]  W_SQR = 2'd1;
   localparam logic [1:0]  W_TRI = 2'd2;

   logic [7:0]    r_freq [CH];
   logic [1:0]    r_w    [CH];
   logic [6:0]    r_amd  [CH];
   logic [6:0]    r_pmd  [CH];
   logic [PW-1:0] r_ph   [CH];
   logic [14:0]   r_lfsr [CH];
   logic [7:0]    r_am   [CH];
   logic [7:0]    r_pm   [CH];
   logic [CW-1:0] r_sc;

   logic [7:0]         w_freq;
   logic [1:0]         w_w;
   logic [6:0]         w_amd;
   logic [6:0]         w_pmd;
   logic [3:0]         w_oct;
   logic [PW-1:0]      w_mant;
   logic [PW-1:0]      w_inc;
   logic [PW:0]        w_sum;
   logic [PW-1:0]      w_ph;
   logic [14:0]        w_lfsr;
   logic [7:0]         w_p;
   logic [7:0]         w_b;
   logic [14:0]        w_amp;
   logic [7:0]         w_s;
   logic signed [15:0] w_pmp;
   logic [7:0]         w_am;
   logic [7:0]         w_pm;
   logic [31:0]        w_chk;
   logic               w_ch_ok;
   logic [CW-1:0]      w_sc_nxt;

   // Datapath for the channel currently selected by the scan counter
   always_comb begin
      w_freq = r_freq[r_sc];
      w_w    = r_w[r_sc];
      w_amd  = r_amd[r_sc];
      w_pmd  = r_pmd[r_sc];
      w_oct  = w_freq[7:4];
      w_mant = {{(PW-5){1'b0}}, 1'b1, w_freq[3:0]};
      if (w_oct >= 4'd4)
         w_inc = w_mant << (w_oct - 4'd4);
      else
         w_inc = w_mant >> (4'd4 - w_oct);
      if (w_freq == 8'd0)
         w_inc = '0;
      if (test[1]) begin
         w_inc = '0;
         w_inc[PW-8] = 1'b1;
      end
      if (test[0])
         w_inc = '0;
      w_sum  = {1'b0, r_ph[r_sc]} + {1'b0, w_inc};
      w_ph   = w_sum[PW-1:0];
      w_lfsr = r_lfsr[r_sc];
      if (w_sum[PW])
         w_lfsr = {w_lfsr[13:0], w_lfsr[14] ^ w_lfsr[13]};
      w_p = w_ph[PW-1:PW-8];
      case (w_w)
         W_SAW:   w_b = w_p;
         W_SQR:   w_b = w_p[7] ? 8'h00 : 8'hff;
         W_TRI:   w_b = w_p[7] ? ~{w_p[6:0], 1'b0} : {w_p[6:0], 1'b0};
         default: w_b = w_lfsr[7:0];
      endcase
      w_amp = {7'd0, w_b} * {8'd0, w_amd};
      w_am  = 8'(w_amp >> 7);
      w_s   = w_b ^ 8'h80;
      w_pmp = $signed({{8{w_s[7]}}, w_s}) * $signed({9'd0, w_pmd});
      w_pm  = (w_pmd == 7'd0) ? 8'd0 : 8'(w_pmp >>> 7);
   end

   // Write-range check and scan counter wrap
   always_comb begin
      w_chk    = 32'(cfg_ch);
      w_ch_ok  = (w_chk < CH);
      w_sc_nxt = (r_sc == CW'(CH - 1)) ? '0 : r_sc + 1'b1;
   end

   // Scan update, config writes and phase sync; a phase sync overrides
   // the same-edge update of its channel
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sc   <= '0;
         upd    <= 1'b0;
         upd_ch <= '0;
         for (int i = 0; i < CH; i++) begin
            r_freq[i] <= '0;
            r_w[i]    <= '0;
            r_amd[i]  <= '0;
            r_pmd[i]  <= '0;
            r_ph[i]   <= '0;
            r_lfsr[i] <= LFSR_INIT;
            r_am[i]   <= '0;
            r_pm[i]   <= '0;
         end
      end else begin
         upd <= cen;
         if (cen) begin
            r_ph[r_sc]   <= w_ph;
            r_lfsr[r_sc] <= w_lfsr;
            r_am[r_sc]   <= w_am;
            r_pm[r_sc]   <= w_pm;
            upd_ch       <= r_sc;
            r_sc         <= w_sc_nxt;
         end
         if (cfg_we && w_ch_ok) begin
            r_freq[cfg_ch] <= cfg_freq;
            r_w[cfg_ch]    <= cfg_w;
            r_amd[cfg_ch]  <= cfg_amd;
            r_pmd[cfg_ch]  <= cfg_pmd;
            if (cfg_up) begin
               r_ph[cfg_ch]   <= '0;
               r_lfsr[cfg_ch] <= LFSR_INIT;
            end
         end
      end
   end

   // Flatten per-channel results onto the output buses
   always_comb begin
      am = '0;
      pm = '0;
      for (int i = 0; i < CH; i++) begin
         am[i*8 +: 8] = r_am[i];
         pm[i*8 +: 8] = r_pm[i];
      end
   end

endmodule
